// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial_tx / serial_rx pair: word width, default divider
// and FSM state encoding.
package serial_tx_pkg;

    localparam int unsigned SER_DATA_W  = 10;
    localparam int unsigned SER_CLK_DIV = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } ser_state_e;

endpackage

// File: rtl/serial_tx_phase_gen.sv
// Half-period divider for serial_tx: counts clk cycles while running and ticks
// phase_end_o on the last cycle of each serial_clk phase.
module serial_tx_phase_gen
    import serial_tx_pkg::*;
#(
    parameter int unsigned CLK_DIV = SER_CLK_DIV
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run_i,
    input  logic clear_i,
    output logic phase_end_o
);

    localparam int unsigned     CntW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign phase_end_o = run_i && !clear_i && (cnt_q == CntMax);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !run_i) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// 2-wire serial transmitter: shifts a DATA_W word out MSB-first on serial_data,
// changing data only while serial_clk is low. All outputs are registered.
module serial_tx
    import serial_tx_pkg::*;
#(
    parameter int unsigned DATA_W  = SER_DATA_W,
    parameter int unsigned CLK_DIV = SER_CLK_DIV
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic              done,
    output logic              serial_clk,
    output logic              serial_data
);

    localparam int unsigned     BitW    = $clog2(DATA_W);
    localparam logic [BitW-1:0] LastBit = BitW'(DATA_W - 1);

    ser_state_e        state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BitW-1:0]   bit_q, bit_d;
    logic              sclk_q, sclk_d;
    logic              sdata_q, sdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              phase_run;
    logic              phase_end;

    assign phase_run = enable && ((state_q == ST_LOW) || (state_q == ST_HIGH));

    serial_tx_phase_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_phase_gen (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .run_i       (phase_run),
        .clear_i     (!enable),
        .phase_end_o (phase_end)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        sclk_d  = sclk_q;
        sdata_d = sdata_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        // Abort takes priority over any start or phase event.
        if (!enable) begin
            state_d = ST_IDLE;
            shift_d = '0;
            bit_d   = '0;
            sclk_d  = 1'b0;
            sdata_d = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_LOW;
                        shift_d = data_in;
                        bit_d   = '0;
                        sclk_d  = 1'b0;
                        sdata_d = data_in[DATA_W-1];
                        busy_d  = 1'b1;
                    end
                end
                ST_LOW: begin
                    if (phase_end) begin
                        state_d = ST_HIGH;
                        sclk_d  = 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (phase_end) begin
                        sclk_d = 1'b0;
                        if (bit_q == LastBit) begin
                            state_d = ST_DONE;
                            sdata_d = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_LOW;
                            shift_d = shift_q << 1;
                            sdata_d = shift_q[DATA_W-2];
                            bit_d   = bit_q + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            sclk_q  <= 1'b0;
            sdata_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            sclk_q  <= sclk_d;
            sdata_q <= sdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign serial_clk  = sclk_q;
    assign serial_data = sdata_q;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: two instances (CLK_DIV 2 and 3) checked every cycle against a
// frame-timeline model, plus a bit-sampling receiver that reassembles each word.
module tb_serial_tx;

    localparam int W  = 10;
    localparam int C0 = 2;
    localparam int C1 = 3;

    logic         clk     = 1'b0;
    logic         rst_n   = 1'b0;
    logic         enable  = 1'b0;
    logic         start   = 1'b0;
    logic [W-1:0] data_in = '0;
    logic [1:0]   busy_w, done_w, sclk_w, sdata_w;

    serial_tx #(
        .DATA_W  (W),
        .CLK_DIV (C0)
    ) u_dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .start       (start),
        .data_in     (data_in),
        .busy        (busy_w[0]),
        .done        (done_w[0]),
        .serial_clk  (sclk_w[0]),
        .serial_data (sdata_w[0])
    );

    serial_tx #(
        .DATA_W  (W),
        .CLK_DIV (C1)
    ) u_dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .start       (start),
        .data_in     (data_in),
        .busy        (busy_w[1]),
        .done        (done_w[1]),
        .serial_clk  (sclk_w[1]),
        .serial_data (sdata_w[1])
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    // Model: frame in flight, cycles since the accepting edge, word, done cycle.
    bit           mact  [2];
    int           mk    [2];
    logic [W-1:0] mword [2];
    bit           mdone [2];

    // Receiver side, fed only from observed serial_clk / serial_data.
    logic [W-1:0] rxw   [2];
    int           rxn   [2];
    int           bcnt  [2];
    logic         psclk [2];
    int           dones [2];

    function automatic int cdiv(input int i);
        return (i == 0) ? C0 : C1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_advance();
        for (int i = 0; i < 2; i++) begin
            if (!rst_n || !enable) begin
                mact[i]  = 1'b0;
                mdone[i] = 1'b0;
            end else if (mact[i]) begin
                mk[i]++;
                if (mk[i] > 2 * W * cdiv(i)) begin
                    mact[i]  = 1'b0;
                    mdone[i] = 1'b1;
                end
            end else if (mdone[i]) begin
                mdone[i] = 1'b0;
            end else if (start) begin
                mact[i]  = 1'b1;
                mk[i]    = 1;
                mword[i] = data_in;
            end
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            logic eb, ed, ec, es;
            int   p;
            eb = 1'b0;
            ed = 1'b0;
            ec = 1'b0;
            es = 1'b0;
            if (mact[i]) begin
                p  = (mk[i] - 1) / cdiv(i);
                eb = 1'b1;
                ec = ((p % 2) == 1);
                es = mword[i][W-1-p/2];
            end else if (mdone[i]) begin
                ed = 1'b1;
            end
            check($sformatf("busy%0d", i), 32'(busy_w[i]), 32'(eb));
            check($sformatf("done%0d", i), 32'(done_w[i]), 32'(ed));
            check($sformatf("sclk%0d", i), 32'(sclk_w[i]), 32'(ec));
            check($sformatf("sdata%0d", i), 32'(sdata_w[i]), 32'(es));

            if (sclk_w[i] && !psclk[i]) begin
                rxw[i] = {rxw[i][W-2:0], sdata_w[i]};
                rxn[i]++;
            end
            psclk[i] = sclk_w[i];
            if (busy_w[i]) bcnt[i]++;
            if (done_w[i]) begin
                dones[i]++;
                check($sformatf("rx_word%0d", i), 32'(rxw[i]), 32'(mword[i]));
                check($sformatf("rx_edges%0d", i), 32'(rxn[i]), 32'(W));
                check($sformatf("busy_len%0d", i), 32'(bcnt[i]), 32'(2 * W * cdiv(i)));
                rxn[i]  = 0;
                bcnt[i] = 0;
            end else if (!busy_w[i]) begin
                rxn[i]  = 0;
                bcnt[i] = 0;
            end
        end
    endtask

    task automatic tick();
        model_advance();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic send(input logic [W-1:0] w);
        start   = 1'b1;
        data_in = w;
        tick();
        start   = 1'b0;
        data_in = 10'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((mact[0] || mact[1] || mdone[0] || mdone[1]) && n < 2000) begin
            tick();
            n++;
        end
        tick();
    endtask

    logic [W-1:0] words [4] = '{10'h000, 10'h3FF, 10'h155, 10'h2AA};

    initial begin
        int n;
        int d0;
        for (int i = 0; i < 2; i++) begin
            mact[i]  = 1'b0;
            mdone[i] = 1'b0;
            mk[i]    = 0;
            mword[i] = '0;
            rxw[i]   = '0;
            rxn[i]   = 0;
            bcnt[i]  = 0;
            psclk[i] = 1'b0;
            dones[i] = 0;
        end

        // Reset held with start and enable asserted.
        rst_n   = 1'b0;
        enable  = 1'b1;
        start   = 1'b1;
        data_in = 10'h3FF;
        repeat (3) tick();
        rst_n = 1'b0;
        start = 1'b0;
        rst_n = 1'b1;
        repeat (5) tick();

        send(10'h2A5);
        wait_idle();
        check("done_count_basic", 32'(dones[0]), 32'd1);

        foreach (words[k]) begin
            send(words[k]);
            wait_idle();
        end
        check("done_count_loop0", 32'(dones[0]), 32'd5);
        check("done_count_loop1", 32'(dones[1]), 32'd5);

        // start held high while data_in churns.
        start = 1'b1;
        for (int k = 0; k < 250; k++) begin
            data_in = 10'($urandom);
            tick();
        end
        start = 1'b0;
        wait_idle();

        // Abort after the 4th rising edge, then a full frame.
        send(10'h1C3);
        n = 0;
        while (rxn[0] < 4 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("edge4_wait", 32'(rxn[0]), 32'd4);
        d0     = dones[0];
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        check("abort_no_done", 32'(dones[0] - d0), 32'd0);
        send(10'h0F0);
        wait_idle();
        check("after_abort_frame", 32'(dones[0] - d0), 32'd1);

        // One-cycle reset during a HIGH phase of the slower instance.
        send(10'h36C);
        n = 0;
        while (!sclk_w[1] && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("high_wait", 32'(sclk_w[1]), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        wait_idle();

        // Random traffic with occasional abort and reset.
        for (int k = 0; k < 1500; k++) begin
            rst_n   = ($urandom_range(0, 199) != 0);
            enable  = ($urandom_range(0, 99) != 0);
            start   = ($urandom_range(0, 3) == 0);
            data_in = 10'($urandom);
            tick();
        end
        rst_n  = 1'b1;
        enable = 1'b1;
        start  = 1'b0;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
- 2-wire serial transmitter for the output operation. The ASIC generates the serial clock and shifts a 10-bit word out MSB-first.
- The microcontroller samples serial_data on each rising edge of serial_clk.
- Sits beside serial_rx in the I/O path and is its wire-compatible counterpart: a serial_tx driving a serial_rx directly must deliver the word intact.

Parameters:
- DATA_W, 10, word width in bits; the bit counter is 4 bits wide.
- CLK_DIV, 4, clk cycles per serial_clk half-period; legal range 2..255.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk
- enable  input  1  transmitter enable; low aborts any transfer and holds the block idle
- start  input  1  request to send data_in; honoured only in IDLE with enable high
- data_in  input  DATA_W  word to send; captured on the accepted start cycle
- busy  output  1  high from the cycle after start is accepted until the frame completes
- done  output  1  one-cycle pulse when the last bit's high phase ends
- serial_clk  output  1  clock to the microcontroller; idles low
- serial_data  output  DATA_W-1..0 shifted MSB-first, 1 bit wide; idles low

Behaviour:
- Clock and reset:
  - Everything is clocked on posedge clk. The block has one clock domain and no synchronizers.
  - While rst_n=0 at a posedge: state=IDLE, busy=0, done=0, serial_clk=0, serial_data=0, and shift register, divider and bit counter all 0.
  - Reset mid-frame behaves the same way: the frame is truncated and done does not pulse.
- All outputs are registered. There are no combinational paths from input to output.
- State machine (IDLE, LOW, HIGH, DONE):
  - IDLE, with enable=1 and start=1 at edge T:
    - shift register <= data_in.
    - At T+1: serial_data=data_in[DATA_W-1], serial_clk=0, busy=1, state=LOW, div=0, bit=0.
    - start is ignored in every other state and whenever enable=0.
  - LOW: serial_clk=0 for CLK_DIV cycles; this is the setup time. Then serial_clk goes to 1 and state=HIGH.
  - HIGH: serial_clk=1 for CLK_DIV cycles. serial_data is stable across the rising edge and the whole high phase. When the phase ends:
    - If bit < DATA_W-1: serial_clk goes to 0, shift left by one, serial_data=next bit, bit+1, state=LOW. Data changes only on the falling edge.
    - If bit == DATA_W-1: serial_clk goes to 0, serial_data goes to 0, state=DONE.
  - DONE: lasts exactly one cycle with done=1 and busy=0, then IDLE.
    - A start asserted during the DONE cycle is ignored.
    - Back-to-back frames therefore have at least one idle cycle between them, with serial_clk low.
- Frame timing:
  - busy is high for exactly 2*CLK_DIV*DATA_W cycles.
  - done=1 at cycle T+1+2*CLK_DIV*DATA_W.
  - serial_clk produces exactly DATA_W rising edges per frame.
- Divider: counts 0..CLK_DIV-1 and the phase toggles at terminal count. The counter is sized to hold CLK_DIV-1 and wraps to 0 at every phase change.
- enable=0 in any state: at the next edge, state=IDLE, serial_clk=0, serial_data=0, busy=0, done=0, counters cleared. No partial frame is resumed.
- Simultaneous events:
  - enable=0 together with start: the abort wins and the start is not captured.
  - rst_n=0 overrides everything.
- data_in is don't-care except on the accepted start cycle. Changes during busy do not affect the frame in flight.
- Compatibility: serial_rx requires each serial_clk level to be held for ≥2 of its clk cycles after its 2-flop synchronizer. CLK_DIV≥2 in the same clock domain satisfies this.

Decomposition:
- Shared package / include:
  - state encodings ST_IDLE=2'd0, ST_LOW=2'd1, ST_HIGH=2'd2, ST_DONE=2'd3.
  - SER_DATA_W=10, shared with serial_rx.
  - Default SER_CLK_DIV.
- One natural sub-module: serial_tx_phase_gen. It holds the divider counter and emits a one-cycle phase_end tick given run/clear inputs.
- The FSM, shift register and bit counter stay in serial_tx.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with start=1 and enable=1 -> busy=0, done=0, serial_clk=0, serial_data=0 throughout; no frame after release until a fresh start.
- Basic frame, CLK_DIV=2, data_in=10'h2A5 -> 10 rising edges, with bits sampled at the rising edges = 1,0,1,0,1,0,0,1,0,1; busy high 40 cycles; done pulses once at T+41; serial_data changes only while serial_clk=0.
- Loopback into serial_rx (same clk, enable=1) for 10'h000, 10'h3FF, 10'h155, 10'h2AA -> rx done asserted and data_out equals each sent word.
- start held high continuously, CLK_DIV=3 -> frames separated by exactly one DONE cycle plus the IDLE accept cycle; data_in changed mid-frame does not corrupt the frame in flight.
- enable dropped after the 4th rising edge -> next cycle serial_clk=0, serial_data=0, busy=0; done never pulses; the following start sends a full 10-bit frame.
- Mid-frame rst_n=0 for 1 cycle during a HIGH phase -> all outputs 0 on the next cycle, no done, FSM in IDLE.
